mult_unit: RTL

Multicycle 32x32 -> 64-bit integer multiplier for the MIPS execute stage; it services MULT/MULTU and produces the HI/LO pair. It uses radix-2 shift-add, one partial-product add per cycle. That add is a 32-bit carry-lookahead adder built from eight chained four_bit_cla_adder slices, so this block is the sequential stage that feeds those slices and consumes their sum and carry. The pipeline control stalls on `busy` and writes HI/LO on `done`.

---
 rtl/mult_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mult_unit.sv
// Multicycle 32x32 -> 64 shift-add multiplier (MULT/MULTU) producing HI/LO.
// One partial-product add per cycle through a 32-bit CLA built from 4-bit slices.

module four_bit_cla_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c;
  end
endmodule

module cla_adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        cout
);
  // Separate carry nets keep the slice chain free of self-referencing vectors.
  logic c1, c2, c3, c4, c5, c6, c7;

  four_bit_cla_adder u_s0 (.a(a[3:0]),   .b(b[3:0]),   .cin(1'b0), .sum(sum[3:0]),   .cout(c1));
  four_bit_cla_adder u_s1 (.a(a[7:4]),   .b(b[7:4]),   .cin(c1),   .sum(sum[7:4]),   .cout(c2));
  four_bit_cla_adder u_s2 (.a(a[11:8]),  .b(b[11:8]),  .cin(c2),   .sum(sum[11:8]),  .cout(c3));
  four_bit_cla_adder u_s3 (.a(a[15:12]), .b(b[15:12]), .cin(c3),   .sum(sum[15:12]), .cout(c4));
  four_bit_cla_adder u_s4 (.a(a[19:16]), .b(b[19:16]), .cin(c4),   .sum(sum[19:16]), .cout(c5));
  four_bit_cla_adder u_s5 (.a(a[23:20]), .b(b[23:20]), .cin(c5),   .sum(sum[23:20]), .cout(c6));
  four_bit_cla_adder u_s6 (.a(a[27:24]), .b(b[27:24]), .cin(c6),   .sum(sum[27:24]), .cout(c7));
  four_bit_cla_adder u_s7 (.a(a[31:28]), .b(b[31:28]), .cin(c7),   .sum(sum[31:28]), .cout(cout));
endmodule

// state | meaning
// IDLE  | waiting for start
// CALC  | 32 shift-add iterations, one partial product per cycle
// FIX   | apply sign to the magnitude product, register into hi/lo
// DONE  | done pulse; a new start here launches with no idle gap
module mult_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] p_q, p_d;
  logic [31:0] ma_q, ma_d;
  logic        s_q, s_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        add_c;
  logic [63:0] prod_fix;

  // Gating the addend to zero is the 2:1 mux: a skipped add passes P[63:32] through.
  assign add_b = p_q[0] ? ma_q : 32'd0;

  cla_adder_32 u_cla (
    .a    (p_q[63:32]),
    .b    (add_b),
    .sum  (add_sum),
    .cout (add_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      p_q     <= 64'd0;
      ma_q    <= 32'd0;
      s_q     <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      ma_q    <= ma_d;
      s_q     <= s_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    ma_d     = ma_q;
    s_d      = s_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    prod_fix = s_q ? (~p_q + 64'd1) : p_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_CALC: begin
        p_d   = {add_c, add_sum, p_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        {hi_d, lo_d} = prod_fix;
        state_d      = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    if (accept) begin
      s_d     = is_signed & (a[31] ^ b[31]);
      ma_d    = (is_signed & a[31]) ? (~a + 32'd1) : a;
      p_d     = {32'd0, ((is_signed & b[31]) ? (~b + 32'd1) : b)};
      cnt_d   = 5'd0;
      state_d = S_CALC;
    end
  end

  assign busy = (state_q == S_CALC) || (state_q == S_FIX);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule
